// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, state and access-size types for the load/store unit
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, ACCESS, LOAD_RESP} lsu_state_t;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_t;

  // Unsigned byte/half codes only exist for loads; a store with those codes is a word store.
  function automatic lsu_size_t size_of(input logic [2:0] f3, input logic is_load);
    lsu_size_t sz;
    sz = SZ_W;
    if (f3 == F3_B || (is_load && f3 == F3_BU)) begin
      sz = SZ_B;
    end else if (f3 == F3_H || (is_load && f3 == F3_HU)) begin
      sz = SZ_H;
    end
    return sz;
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// rtl/load_store_unit_align.sv - extracts and extends the addressed byte/half/word of a load
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = word[{off, 3'b000} +: 8];
  assign half_v = word[{off[1], 4'b0000} +: 16];

  // Pick the lane and extend it; unknown codes fall back to a full word.
  always_comb begin
    data = word;
    case (funct3)
      F3_B:    data = {{24{byte_v[7]}}, byte_v};
      F3_H:    data = {{16{half_v[15]}}, half_v};
      F3_BU:   data = {24'h0, byte_v};
      F3_HU:   data = {16'h0, half_v};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - handshake-driven load/store unit in front of a synchronous data memory
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [31:0]           addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     rdata,
  output logic                  misaligned,
  output logic                  stall,
  output logic [DM_ADDRESS-1:0] dm_addr,
  output logic                  dm_we,
  output logic [3:0]            dm_be,
  output logic [DATA_W-1:0]     dm_wdata,
  input  logic [DATA_W-1:0]     dm_rdata
);

  lsu_state_t              state, state_n;
  logic [DM_ADDRESS+1:0]   addr_q;
  logic [2:0]              f3_q;
  logic [DATA_W-1:0]       wdata_q;
  logic                    is_load_q;
  logic [DATA_W-1:0]       rdata_q;
  logic [DATA_W-1:0]       load_data;
  logic [1:0]              off;
  lsu_size_t               sz;
  logic                    mis;
  logic                    accept;

  // Upper address bits lie outside the data memory and are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[31:DM_ADDRESS+2];

  assign off       = addr_q[1:0];
  assign sz        = size_of(f3_q, is_load_q);
  assign mis       = (sz == SZ_H && off[0]) || (sz == SZ_W && off != 2'b00);
  assign accept    = req_valid && req_ready && (mem_read || mem_write);
  assign req_ready = (state == IDLE);
  assign stall     = (state != IDLE);
  assign dm_addr   = addr_q[DM_ADDRESS+1:2];

  load_align u_align (
    .word   (dm_rdata),
    .off    (off),
    .funct3 (f3_q),
    .data   (load_data)
  );

  // State register, request capture, and held load result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      f3_q      <= '0;
      wdata_q   <= '0;
      is_load_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        addr_q    <= addr[DM_ADDRESS+1:0];
        f3_q      <= funct3;
        wdata_q   <= wdata;
        is_load_q <= mem_read;
      end
      if (state == LOAD_RESP) begin
        rdata_q <= load_data;
      end
    end
  end

  // Next state, memory strobes and response; reset suppresses any in-flight response or write.
  always_comb begin
    state_n    = state;
    dm_we      = 1'b0;
    dm_be      = 4'b0000;
    dm_wdata   = '0;
    resp_valid = 1'b0;
    misaligned = 1'b0;
    rdata      = rdata_q;
    case (state)
      IDLE: begin
        if (accept) state_n = ACCESS;
      end
      ACCESS: begin
        state_n = (is_load_q && !mis) ? LOAD_RESP : IDLE;
        if (mis) begin
          resp_valid = 1'b1;
          misaligned = 1'b1;
          rdata      = '0;
        end else if (!is_load_q) begin
          dm_we      = 1'b1;
          resp_valid = 1'b1;
          case (sz)
            SZ_B: begin
              dm_be    = 4'b0001 << off;
              dm_wdata = {4{wdata_q[7:0]}};
            end
            SZ_H: begin
              dm_be    = off[1] ? 4'b1100 : 4'b0011;
              dm_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
              dm_be    = 4'b1111;
              dm_wdata = wdata_q;
            end
          endcase
        end
      end
      LOAD_RESP: begin
        state_n    = IDLE;
        resp_valid = 1'b1;
        rdata      = load_data;
      end
      default: state_n = IDLE;
    endcase
    if (reset) begin
      dm_we      = 1'b0;
      dm_be      = 4'b0000;
      resp_valid = 1'b0;
      misaligned = 1'b0;
      rdata      = '0;
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Load/store unit between the EX/MEM pipeline register and the data memory array.
- Accepts one memory request per transaction through a valid/ready handshake.
- Drives the memory with a word address, byte enables and lane-replicated write data.
- Returns aligned, sign/zero-extended load data.
- Holds the pipeline via stall while a transaction is in flight and flags misaligned accesses instead of issuing them.

Parameters:
DM_ADDRESS, 9, width of the data-memory word index.
DATA_W, 32, data width; fixed at 32 for RV32, other values unsupported.

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  EX/MEM presents a request
req_ready  out  1  unit can accept a request this cycle
mem_read  in  1  request is a load
mem_write  in  1  request is a store
funct3  in  3  instruction bits 14:12 (size/sign)
addr  in  32  byte address from ALU
wdata  in  32  store data (rs2)
resp_valid  out  1  one-cycle completion pulse (loads and stores)
rdata  out  32  aligned load result, valid with resp_valid
misaligned  out  1  qualifies resp_valid: access rejected as misaligned
stall  out  1  hold upstream stages
dm_addr  out  DM_ADDRESS  word index = addr[DM_ADDRESS+1:2]
dm_we  out  1  memory write strobe
dm_be  out  4  byte-lane enables
dm_wdata  out  32  lane-replicated write data
dm_rdata  in  32  memory read word, synchronous read, valid the cycle after dm_addr

Behaviour:
- Reset values: state IDLE; req_ready=1; stall=0; resp_valid=0; misaligned=0; rdata=0; dm_we=0; dm_be=0; dm_addr=0; dm_wdata=0.
- States: IDLE, ACCESS, LOAD_RESP.
  - req_ready = (state==IDLE).
  - stall = (state!=IDLE).
- Acceptance and request registration:
  - A request is accepted when req_valid && req_ready && (mem_read || mem_write).
  - If req_valid is high with neither mem_read nor mem_write, the request is ignored and the unit stays in IDLE.
  - On acceptance, addr, funct3, wdata and the op are registered.
  - mem_read && mem_write together: treat as a load (read has priority).
- Size decode:
  - Loads: funct3 000=LB, 001=LH, 010=LW, 100=LBU, 101=LHU; any other value is treated as LW.
  - Stores: funct3 000=SB, 001=SH, 010=SW; any other value is treated as SW.
- Misalignment:
  - Halfword access with off[0]=1, or word access with off!=0, where off = addr[1:0].
  - In the ACCESS cycle a misaligned request drives dm_we=0, resp_valid=1, misaligned=1, rdata=0, then returns to IDLE. Memory is untouched.
- Store (ACCESS, one cycle):
  - dm_we=1.
  - SB: dm_be = 0001<<off, dm_wdata = {4{wdata[7:0]}}.
  - SH: dm_be = off[1] ? 1100 : 0011, dm_wdata = {2{wdata[15:0]}}.
  - SW: dm_be = 1111, dm_wdata = wdata.
  - resp_valid=1 in the same cycle, then state goes to IDLE.
- Load:
  - ACCESS drives dm_addr with dm_we=0, then moves to LOAD_RESP.
  - In LOAD_RESP, byte = dm_rdata[8*off +: 8] and half = dm_rdata[16*off[1] +: 16], extended per funct3.
  - rdata is registered so it holds until the next load completes; resp_valid=1 for one cycle, then state goes to IDLE.
- Latency, with acceptance in cycle T:
  - Store: write and response in T+1.
  - Load: rdata/resp_valid in T+2.
  - Next acceptance possible at T+2 (store) or T+3 (load).
- dm_we is asserted only in ACCESS for an aligned store; never for two consecutive cycles.
- Reset mid-operation: next edge forces IDLE, dm_we=0, and no resp_valid for the aborted request.

Decomposition:
- Package lsu_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - state enum lsu_state_t {IDLE, ACCESS, LOAD_RESP}.
  - function size_of(funct3).
- Sub-module load_align: combinational; inputs word, off, funct3; output extracted and extended 32-bit value. Instantiated once on the load path.

Test Plan:
- SW addr=0x0000_0010 wdata=0xDEADBEEF -> T+1: dm_addr=4, dm_be=1111, dm_wdata=0xDEADBEEF, dm_we=1, resp_valid=1; req_ready=0 at T+1, 1 at T+2.
- SB addr=0x13 wdata=0x000000A5 -> dm_addr=4, dm_be=1000, dm_wdata=0xA5A5A5A5; follow with LW addr=0x10 returning 0xA5ADBEEF -> rdata=0xA5ADBEEF at T+2.
- LB/LBU addr=0x13 with dm_rdata=0x80112233 -> LB rdata=0xFFFFFF80, LBU rdata=0x00000080; LH addr=0x12 -> 0xFFFF8011; LHU -> 0x00008011.
- LW addr=0x12 and SH addr=0x11 -> resp_valid=1, misaligned=1, rdata=0, dm_we never asserted, back to IDLE at T+2.
- Back-to-back req_valid held high with a load then a store -> stall high T+1..T+2, store accepted at T+3, exactly one resp_valid per request.
- Assert reset during LOAD_RESP -> no resp_valid, IDLE next cycle, req_ready=1; req_valid with mem_read=mem_write=0 -> never accepted, stall stays 0.
